adc_multi: RTL and testbench



---
 rtl/adc_pkg.sv | 27 ++
 rtl/adc_ramp_bank.sv | 44 ++++
 rtl/adc_multi.sv | 153 +++++++++++++++
 tb/tb_adc_multi.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and helpers for the multi-channel ADC model
//
// Contents:
//   state_e     : FSM state encoding (ST_IDLE, ST_CONV)
//   MODE_SINGLE : mode input value for a single-channel conversion
//   MODE_SCAN   : mode input value for a scan of every channel
//   clog2_min1  : ceil(log2(n)) clamped to at least 1, used for index widths
package adc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/adc_ramp_bank.sv
// rtl/adc_ramp_bank.sv - per-channel deterministic sample ramps
//
// Ports:
//   clk    in  1      clock, rising edge
//   rst    in  1      synchronous active-high reset, clears every ramp
//   adv    in  1      advance ramp[ch] by ch+1 (wraps modulo 2^WIDTH)
//   ch     in  CW     channel addressed for read and advance
//   sample out WIDTH  ramp[ch], combinational read (value before any advance)
module adc_ramp_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CW       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [CW-1:0]    ch,
  output logic [WIDTH-1:0] sample
);

  logic [WIDTH-1:0] ramp_q [CHANNELS];
  logic [WIDTH-1:0] ramp_d [CHANNELS];

  assign sample = ramp_q[ch];

  // Step size differs per channel so each channel's sequence is distinguishable.
  always_comb begin
    ramp_d = ramp_q;
    if (adv) begin
      ramp_d[ch] = ramp_q[ch] + WIDTH'(ch) + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ramp_q[i] <= '0;
      end
    end else begin
      ramp_q <= ramp_d;
    end
  end

endmodule

// File: rtl/adc_multi.sv
// rtl/adc_multi.sv - clocked multi-channel ADC model with single and scan modes
//
// Optional feature macro: ADC_MULTI_OVR_EN (sticky overrun flag on req while busy).
//
// Ports:
//   clk    in  1      clock, rising edge
//   rst    in  1      synchronous active-high reset
//   req    in  1      conversion request, sampled each edge
//   mode   in  1      0 = single, 1 = scan; sampled when req is accepted
//   ch_sel in  CW     channel for single mode; sampled when req is accepted
//   busy   out 1      conversion in progress
//   rdy    out 1      one-cycle pulse, dat/dat_ch just updated
//   dat    out WIDTH  last converted sample, held until the next result
//   dat_ch out CW     channel of dat
//   ovr    out 1      sticky overrun flag (constant 0 unless ADC_MULTI_OVR_EN)
module adc_multi
  import adc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int CONV_CYCLES = 4,
  localparam int CW         = clog2_min1(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             mode,
  input  logic [CW-1:0]    ch_sel,
  output logic             busy,
  output logic             rdy,
  output logic [WIDTH-1:0] dat,
  output logic [CW-1:0]    dat_ch,
  output logic             ovr
);

  // Counter runs CONV_CYCLES-1 down to 0; the edge seen at 0 completes.
  localparam int               CNT_W    = clog2_min1(CONV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CW-1:0]    LAST_CH  = CW'(CHANNELS - 1);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CW-1:0]      ch_q, ch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dat_q, dat_d;
  logic [CW-1:0]      dat_ch_q, dat_ch_d;
  logic               rdy_q, rdy_d;
  logic               adv;
  logic               ch_ok;
  logic [31:0]        ch_sel_ext;
  logic [WIDTH-1:0]   sample;

  adc_ramp_bank #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .CW      (CW)
  ) u_ramp (
    .clk   (clk),
    .rst   (rst),
    .adv   (adv),
    .ch    (ch_q),
    .sample(sample)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    dat_ch_d = dat_ch_q;
    rdy_d    = 1'b0;
    adv      = 1'b0;

    // Widened compare stays meaningful when CHANNELS is not a power of two.
    ch_sel_ext = 32'(ch_sel);
    ch_ok      = (ch_sel_ext < 32'(CHANNELS));

    case (state_q)
      ST_IDLE: begin
        if (req && (mode == MODE_SCAN || ch_ok)) begin
          mode_d  = mode;
          ch_d    = (mode == MODE_SCAN) ? '0 : ch_sel;
          cnt_d   = CNT_LOAD;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          adv      = 1'b1;
          dat_d    = sample;
          dat_ch_d = ch_q;
          rdy_d    = 1'b1;
          if (mode_q == MODE_SCAN && ch_q != LAST_CH) begin
            ch_d  = ch_q + CW'(1);
            cnt_d = CNT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_SINGLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      dat_q    <= '0;
      dat_ch_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
      dat_ch_q <= dat_ch_d;
      rdy_q    <= rdy_d;
    end
  end

  assign busy   = (state_q == ST_CONV);
  assign rdy    = rdy_q;
  assign dat    = dat_q;
  assign dat_ch = dat_ch_q;

`ifdef ADC_MULTI_OVR_EN
  logic ovr_q, ovr_d;

  // The late request is still dropped by the FSM; this only records it.
  always_comb begin
    ovr_d = ovr_q | (req && state_q == ST_CONV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_adc_multi.sv
// tb/tb_adc_multi.sv - scoreboard bench for adc_multi with default parameters
module tb_adc_multi;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int CONV     = 4;
  localparam int CW       = 2;

`ifdef ADC_MULTI_OVR_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req;
  logic             mode;
  logic [CW-1:0]    ch_sel;
  logic             busy;
  logic             rdy;
  logic [WIDTH-1:0] dat;
  logic [CW-1:0]    dat_ch;
  logic             ovr;

  adc_multi #(
    .WIDTH      (WIDTH),
    .CHANNELS   (CHANNELS),
    .CONV_CYCLES(CONV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .mode  (mode),
    .ch_sel(ch_sel),
    .busy  (busy),
    .rdy   (rdy),
    .dat   (dat),
    .dat_ch(dat_ch),
    .ovr   (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int d;
    int c;
    int t;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", name, act, req_v, cyc);
    end
  endtask

  task automatic push(input int d, input int c, input int t);
    sbq.push_back(exp_t'{d, c, t});
  endtask

  // Monitor: every rdy pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdy actual=rdy dat=%0d ch=%0d cyc=%0d required=no rdy",
                 dat, dat_ch, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("rdy_dat", 32'(dat), mon_e.d);
        chk("rdy_ch", 32'(dat_ch), mon_e.c);
        chk("rdy_cycle", cyc, mon_e.t);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clk);
    chk("idle_reached", 32'(busy), 0);
  endtask

  task automatic single(input int ch, input int exp_dat);
    mode   = 1'b0;
    ch_sel = CW'(ch);
    req    = 1'b1;
    push(exp_dat, ch, cyc + 1 + CONV);
    @(negedge clk);
    req = 1'b0;
    chk("busy_after_accept", 32'(busy), 1);
    wait_idle();
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3);
    mode = 1'b1;
    req  = 1'b1;
    push(d0, 0, cyc + 1 + CONV * 1);
    push(d1, 1, cyc + 1 + CONV * 2);
    push(d2, 2, cyc + 1 + CONV * 3);
    push(d3, 3, cyc + 1 + CONV * 4);
    @(negedge clk);
    req = 1'b0;
    chk("scan_busy_after_accept", 32'(busy), 1);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    req    = 1'b0;
    mode   = 1'b0;
    ch_sel = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_rdy", 32'(rdy), 0);
      chk("idle_dat", 32'(dat), 0);
      chk("idle_dat_ch", 32'(dat_ch), 0);
      chk("idle_ovr", 32'(ovr), 0);
    end

    // Single-mode latency and ramp
    single(2, 0);
    single(2, 3);
    single(2, 6);
    single(0, 0);

    // Scan mode from fresh ramps
    do_reset();
    scan(0, 0, 0, 0);
    scan(1, 2, 3, 4);

    // Busy and overrun
    do_reset();
    mode   = 1'b0;
    ch_sel = 2'd1;
    req    = 1'b1;
    push(0, 1, cyc + 1 + CONV);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_idle();
    chk("ovr_after_busy_req", 32'(ovr), 32'(OVR_EXP));
    repeat (5) @(negedge clk);
    chk("ovr_sticky_idle", 32'(ovr), 32'(OVR_EXP));
    single(1, 2);
    chk("ovr_sticky_after_conv", 32'(ovr), 32'(OVR_EXP));
    do_reset();
    chk("ovr_cleared_by_rst", 32'(ovr), 0);

    // Wrap-around with req held: channel 3 steps by 4, one result per 5 cycles
    do_reset();
    mode   = 1'b0;
    ch_sel = 2'd3;
    req    = 1'b1;
    for (int i = 0; i < 70; i++) begin
      push((4 * i) % 256, 3, cyc + 1 + CONV + (CONV + 1) * i);
    end
    repeat (1 + CONV + (CONV + 1) * 69) @(negedge clk);
    req = 1'b0;
    wait_idle();

    // Reset mid-scan discards the in-flight scan
    do_reset();
    mode = 1'b1;
    req  = 1'b1;
    push(0, 0, cyc + 1 + CONV);
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midscan_rst_busy", 32'(busy), 0);
    chk("midscan_rst_rdy", 32'(rdy), 0);
    repeat (12) @(negedge clk);
    chk("midscan_quiet_busy", 32'(busy), 0);
    single(1, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
